// File: rtl/register_bank.sv
// rtl/register_bank.sv - parametrised Avalon-MM register bank with per-register RW/RO/W1C/PULSE modes
// RW registers are shadowed and copied to their active value on commit (or one cycle later with AUTO_COMMIT).
module register_bank #(
  parameter int                         DATA_W      = 64,
  parameter int                         NUM_REGS    = 8,
  parameter int                         ADDR_W      = $clog2(NUM_REGS),
  parameter logic [NUM_REGS*DATA_W-1:0] RST_VALUES  = '0,
  parameter logic [2*NUM_REGS-1:0]      REG_MODE    = '0,
  parameter int                         AUTO_COMMIT = 0
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [ADDR_W-1:0]            i_address,
  input  logic                         i_write,
  input  logic [DATA_W-1:0]            i_writedata,
  input  logic [DATA_W/8-1:0]          i_byteenable,
  input  logic                         i_read,
  output logic [DATA_W-1:0]            o_readdata,
  output logic                         o_readdatavalid,
  input  logic                         i_commit,
  output logic                         o_commit_ack,
  input  logic [NUM_REGS*DATA_W-1:0]   i_hw_data,
  input  logic [NUM_REGS*DATA_W-1:0]   i_hw_set,
  output logic [NUM_REGS*DATA_W-1:0]   o_regs
);

  localparam int NUM_BYTES = DATA_W / 8;

  logic [DATA_W-1:0]          be_mask;
  logic [NUM_REGS-1:0]        wr_hit;
  logic [NUM_REGS*DATA_W-1:0] rd_flat;
  logic [DATA_W-1:0]          rd_sel;

  always_comb begin
    be_mask = '0;
    for (int b = 0; b < NUM_BYTES; b++) begin
      be_mask[b*8 +: 8] = {8{i_byteenable[b]}};
    end
  end

  always_comb begin
    wr_hit = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      wr_hit[k] = i_write && (i_address == ADDR_W'(k));
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
    localparam logic [DATA_W-1:0] RST  = RST_VALUES[k*DATA_W +: DATA_W];
    localparam logic [1:0]        MODE = REG_MODE[2*k +: 2];

    logic unused_in;
    assign unused_in = ^{i_hw_data[k*DATA_W +: DATA_W], i_hw_set[k*DATA_W +: DATA_W], wr_hit[k]};

    if (MODE == 2'd0) begin : g_rw
      logic [DATA_W-1:0] shadow_q, shadow_d, active_q;

      always_comb begin
        shadow_d = shadow_q;
        if (wr_hit[k]) shadow_d = (shadow_q & ~be_mask) | (i_writedata & be_mask);
      end

      // A commit copies the post-write shadow, so a write in the commit cycle is included.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          shadow_q <= RST;
          active_q <= RST;
        end else begin
          shadow_q <= shadow_d;
          if (AUTO_COMMIT != 0) active_q <= shadow_q;
          else if (i_commit)    active_q <= shadow_d;
        end
      end

      assign rd_flat[k*DATA_W +: DATA_W] = shadow_q;
      assign o_regs[k*DATA_W +: DATA_W]  = active_q;
    end else if (MODE == 2'd1) begin : g_ro
      logic [DATA_W-1:0] value_q;

      always_ff @(posedge i_clk) begin
        if (i_rst) value_q <= RST;
        else       value_q <= i_hw_data[k*DATA_W +: DATA_W];
      end

      assign rd_flat[k*DATA_W +: DATA_W] = value_q;
      assign o_regs[k*DATA_W +: DATA_W]  = value_q;
    end else if (MODE == 2'd2) begin : g_w1c
      logic [DATA_W-1:0] value_q, clr;

      assign clr = wr_hit[k] ? (i_writedata & be_mask) : '0;

      // Hardware set is applied after the clear so a simultaneous set wins.
      always_ff @(posedge i_clk) begin
        if (i_rst) value_q <= RST;
        else       value_q <= (value_q & ~clr) | i_hw_set[k*DATA_W +: DATA_W];
      end

      assign rd_flat[k*DATA_W +: DATA_W] = value_q;
      assign o_regs[k*DATA_W +: DATA_W]  = value_q;
    end else begin : g_pulse
      logic [DATA_W-1:0] value_q;

      always_ff @(posedge i_clk) begin
        if (i_rst)          value_q <= RST;
        else if (wr_hit[k]) value_q <= (value_q & ~be_mask) | (i_writedata & be_mask);
        else                value_q <= RST;
      end

      assign rd_flat[k*DATA_W +: DATA_W] = value_q;
      assign o_regs[k*DATA_W +: DATA_W]  = value_q;
    end
  end

  // Unpopulated addresses match no register and read back as zero.
  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (i_address == ADDR_W'(k)) rd_sel = rd_flat[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_readdata      <= '0;
      o_readdatavalid <= 1'b0;
      o_commit_ack    <= 1'b0;
    end else begin
      o_commit_ack <= i_commit;
      if (i_read && !i_write) begin
        o_readdata      <= rd_sel;
        o_readdatavalid <= 1'b1;
      end else begin
        o_readdata      <= '0;
        o_readdatavalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// tb/tb_register_bank.sv - directed self-checking bench for register_bank
// Map: 0 RW, 1 RW (reset 0xDEADBEEF01234567), 2 W1C, 3 PULSE, 4 RO, 5 RW; addresses 6-7 unpopulated.
module tb_register_bank;

  localparam int DW = 64;
  localparam int NR = 6;
  localparam int AW = 3;
  localparam logic [NR*DW-1:0] RSTV = {64'h0, 64'h0, 64'h0, 64'h0, 64'hDEAD_BEEF_0123_4567, 64'h0};
  localparam logic [2*NR-1:0]  MODES = 12'h1E0;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   address;
  logic            write;
  logic [DW-1:0]   writedata;
  logic [DW/8-1:0] byteenable;
  logic            read;
  logic [DW-1:0]   readdata;
  logic            readdatavalid;
  logic            commit;
  logic            commit_ack;
  logic [NR*DW-1:0] hw_data;
  logic [NR*DW-1:0] hw_set;
  logic [NR*DW-1:0] regs;

  int checks = 0;
  int errors = 0;

  register_bank #(
    .DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW),
    .RST_VALUES(RSTV), .REG_MODE(MODES), .AUTO_COMMIT(0)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_address(address), .i_write(write),
    .i_writedata(writedata), .i_byteenable(byteenable), .i_read(read),
    .o_readdata(readdata), .o_readdatavalid(readdatavalid),
    .i_commit(commit), .o_commit_ack(commit_ack),
    .i_hw_data(hw_data), .i_hw_set(hw_set), .o_regs(regs)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] reg_of(input int k);
    return regs[k*DW +: DW];
  endfunction

  task automatic wr(input logic [AW-1:0] a, input logic [63:0] d, input logic [7:0] be);
    address = a; writedata = d; byteenable = be; write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [AW-1:0] a, input logic [63:0] exp);
    address = a; read = 1'b1;
    tick();
    read = 1'b0;
    check({tag, "_valid"}, readdatavalid, 1);
    check(tag, readdata, exp);
  endtask

  initial begin
    rst = 1'b1; address = '0; write = 1'b0; writedata = '0; byteenable = '0;
    read = 1'b0; commit = 1'b0; hw_data = '0; hw_set = '0;
    tick(); tick();
    rst = 1'b0;

    check("rst_valid", readdatavalid, 0);
    check("rst_rdata", readdata, 0);
    check("rst_ack", commit_ack, 0);
    check("rst_regs0", reg_of(0), 0);
    check("rst_regs1", reg_of(1), 64'hDEAD_BEEF_0123_4567);
    check("rst_regs3", reg_of(3), 0);

    rd_check("rd_rst1", 1, 64'hDEAD_BEEF_0123_4567);
    tick();
    check("rd_idle_valid", readdatavalid, 0);

    // RW with partial byte enables, then a separate commit
    wr(0, 64'h1111_2222_3333_4444, 8'h0F);
    rd_check("rw_shadow0", 0, 64'h0000_0000_3333_4444);
    check("rw_active_pre", reg_of(0), 0);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    check("rw_active_post", reg_of(0), 64'h0000_0000_3333_4444);
    check("ack_pulse", commit_ack, 1);
    tick();
    check("ack_one_cycle", commit_ack, 0);

    // Write and commit in the same cycle on reg 5
    address = 5; writedata = 64'h1111_2222_3333_4444; byteenable = 8'h0F;
    write = 1'b1; commit = 1'b1;
    tick();
    write = 1'b0; commit = 1'b0;
    check("same_cycle_commit", reg_of(5), 64'h0000_0000_3333_4444);
    check("same_cycle_ack", commit_ack, 1);

    // Back-to-back commits
    commit = 1'b1;
    tick();
    check("b2b_ack1", commit_ack, 1);
    tick();
    commit = 1'b0;
    check("b2b_ack2", commit_ack, 1);
    tick();
    check("b2b_ack_end", commit_ack, 0);

    // W1C
    hw_set[2*DW +: DW] = 64'h5;
    tick();
    hw_set = '0;
    rd_check("w1c_set", 2, 64'h5);
    wr(2, 64'h1, 8'hFF);
    rd_check("w1c_clr", 2, 64'h4);
    address = 2; writedata = 64'h4; byteenable = 8'hFF; write = 1'b1;
    hw_set[2*DW +: DW] = 64'h4;
    tick();
    write = 1'b0; hw_set = '0;
    rd_check("w1c_set_wins", 2, 64'h4);
    wr(2, 64'h4, 8'h00);
    rd_check("w1c_be_off", 2, 64'h4);
    wr(2, 64'h4, 8'h01);
    rd_check("w1c_clr2", 2, 64'h0);

    // PULSE
    wr(3, 64'hFF, 8'hFF);
    check("pulse_hi", reg_of(3), 64'hFF);
    tick();
    check("pulse_back", reg_of(3), 0);
    address = 3; writedata = 64'hFF; byteenable = 8'hFF; write = 1'b1;
    tick();
    check("pulse2_a", reg_of(3), 64'hFF);
    writedata = 64'hAB;
    tick();
    write = 1'b0;
    check("pulse2_b", reg_of(3), 64'hAB);
    tick();
    check("pulse2_end", reg_of(3), 0);

    // Unpopulated addresses
    rd_check("unpop6", 6, 0);
    wr(6, '1, 8'hFF);
    wr(7, '1, 8'hFF);
    check("unpop_regs0", reg_of(0), 64'h0000_0000_3333_4444);
    check("unpop_regs1", reg_of(1), 64'hDEAD_BEEF_0123_4567);
    check("unpop_regs2", reg_of(2), 0);
    rd_check("unpop7", 7, 0);
    rd_check("unpop_shadow0", 0, 64'h0000_0000_3333_4444);

    // RO tracking with one cycle of lag
    hw_data[4*DW +: DW] = 64'hA5;
    #1;
    check("ro_lag", reg_of(4), 0);
    tick();
    check("ro_track", reg_of(4), 64'hA5);
    rd_check("ro_read", 4, 64'hA5);

    // Read and write together: write wins, no read response
    address = 1; writedata = 64'h0123; byteenable = 8'hFF; write = 1'b1; read = 1'b1;
    tick();
    write = 1'b0; read = 1'b0;
    check("rw_collide_valid", readdatavalid, 0);
    rd_check("wr_then_rd", 1, 64'h0123);

    // Reset in the same cycle as a commit
    wr(0, 64'h77, 8'hFF);
    hw_set[2*DW +: DW] = 64'h5;
    tick();
    hw_set = '0;
    commit = 1'b1; rst = 1'b1;
    tick();
    commit = 1'b0; rst = 1'b0;
    check("mid_rst_ack", commit_ack, 0);
    check("mid_rst_regs0", reg_of(0), 0);
    check("mid_rst_regs1", reg_of(1), 64'hDEAD_BEEF_0123_4567);
    check("mid_rst_regs2", reg_of(2), 0);
    check("mid_rst_regs4", reg_of(4), 0);
    check("mid_rst_regs5", reg_of(5), 0);
    tick();
    check("mid_rst_ack2", commit_ack, 0);
    rd_check("mid_rst_shadow0", 0, 0);
    rd_check("mid_rst_shadow1", 1, 64'hDEAD_BEEF_0123_4567);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- Parametrised bank of NUM_REGS registers, each DATA_W bits wide, replacing single fixed-width registers in the HPS-to-fabric control path.
- Software accesses it through an Avalon-MM slave port with byte enables and a fixed 1-cycle read latency.
- Each register has its own mode: RW (shadowed, with atomic commit), RO (hardware status), W1C (sticky hardware events) or PULSE (self-clearing strobes).

Parameters:
- DATA_W, 64: register width in bits; must be a multiple of 8.
- NUM_REGS, 8: number of registers; minimum 2.
- ADDR_W, $clog2(NUM_REGS): width of the word address.
- RST_VALUES, all zeros: NUM_REGS*DATA_W flat vector; register k uses slice [k*DATA_W +: DATA_W].
- REG_MODE, all zeros: 2*NUM_REGS flat vector, 2 bits per register; 0=RW, 1=RO, 2=W1C, 3=PULSE.
- AUTO_COMMIT, 0: when 1, RW shadow writes propagate to o_regs without waiting for i_commit.

Ports:
- i_clk, in, 1: sole clock.
- i_rst, in, 1: synchronous, active-high reset.
- i_address, in, ADDR_W: word address.
- i_write, in, 1: write strobe.
- i_writedata, in, DATA_W: write data.
- i_byteenable, in, DATA_W/8: per-byte write enables.
- i_read, in, 1: read strobe.
- o_readdata, out, DATA_W: read data.
- o_readdatavalid, out, 1: read data valid.
- i_commit, in, 1: pulse that copies all RW shadows to their active registers.
- o_commit_ack, out, 1: 1-cycle pulse, the cycle after the active registers update.
- i_hw_data, in, NUM_REGS*DATA_W: live values for RO registers.
- i_hw_set, in, NUM_REGS*DATA_W: per-bit set strobes for W1C registers.
- o_regs, out, NUM_REGS*DATA_W: active register values, flat vector.

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - Every shadow and active register loads its RST_VALUES slice.
  - o_readdata=0, o_readdatavalid=0, o_commit_ack=0.
  - Reset overrides any write, read or commit in the same cycle, including a commit in flight.
- Slave timing: no waitrequest. Every access completes in one cycle. i_read and i_write asserted together: the write executes, the read is ignored.
- Write, RW register: shadow byte b <= i_writedata byte b when i_byteenable[b]=1; other bytes hold.
- Write, RO register: ignored.
- Write, W1C register: bits that are 1 in the written data and inside enabled bytes clear to 0.
- Write, PULSE register: enabled bytes load. The next cycle the register returns to its RST_VALUES slice. A new write in that cycle takes precedence.
- Address >= NUM_REGS: write is ignored.
- W1C set/clear collision: i_hw_set bits OR into the register every cycle. Set wins over a simultaneous software clear of the same bit.
- RO registers: o_regs slice follows i_hw_data with 1-cycle registered latency.
- Commit, AUTO_COMMIT=0:
  - i_commit=1 copies every RW shadow to its active register at that edge.
  - A write in the same cycle as i_commit is included in the copy: the active value equals the post-write shadow.
  - o_commit_ack pulses high for one cycle on the following cycle.
  - Back-to-back commits give back-to-back acks.
- Commit, AUTO_COMMIT=1: each RW active register is updated 1 cycle after its shadow (shadow+1). i_commit still produces o_commit_ack but has no other effect.
- Read latency: i_read at cycle N gives o_readdatavalid=1 at N+1 with o_readdata valid. Otherwise o_readdatavalid=0 and o_readdata=0.
- Read data by register mode:
  - RW: returns the shadow value, not the active value.
  - RO, W1C, PULSE: return the current register value.
  - Address >= NUM_REGS: returns 0.
- Write-then-read to the same address in consecutive cycles: the read returns the written value.
- o_regs:
  - RW: the active value.
  - RO, W1C: the register value.
  - PULSE: the live value, so a strobe appears for exactly one cycle.

Test Plan:
1. Reset with RST_VALUES[reg1]=0xDEAD_BEEF_0123_4567 -> read of addr 1 returns that value at latency 1; o_regs slice 1 matches; all other registers 0.
2. RW addr 0: write 0x1111_2222_3333_4444 with byteenable 0x0F, then pulse i_commit -> shadow reads 0x0000_0000_3333_4444 before commit; o_regs[0] unchanged until the commit edge; o_commit_ack high for exactly one cycle after it. Repeat with write and commit in the same cycle -> committed value 0x0000_0000_3333_4444.
3. W1C reg 2: pulse i_hw_set=0x5 -> reads 0x5. Write 0x1 -> reads 0x4. Write 0x4 in the same cycle as i_hw_set=0x4 -> still 0x4 (set wins).
4. PULSE reg 3: write 0xFF -> o_regs[3]=0xFF for one cycle, then RST value. Two consecutive writes -> o_regs[3] high for two cycles.
5. Read of address NUM_REGS (unpopulated, NUM_REGS power of two not required) -> returns 0; write to it changes nothing. RO reg tracks i_hw_data=0xA5 with 1-cycle lag. Assert i_rst mid-commit -> all values return to RST_VALUES and no o_commit_ack is produced.
